// File: rtl/mm_issue_scheduler.sv
// Issue sequencer for the matrix-multiply datapath: streams every packed A word, then its s words, and counts returned B results.
// Optional macro MM_SCHED_PERF_EN adds stall_cycles_out (cycles an offer waits on a deasserted ready).
module mm_issue_scheduler #(
    parameter int DEPTH   = 784,
    parameter int A_WORDS = 196,
    parameter int RD_LAT  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [9:0]  a_addr_out,
    input  logic [23:0] a_rd_data_in,
    output logic [9:0]  s_addr_out,
    input  logic [3:0]  s_rd_data_in,
    output logic        A_valid_out,
    output logic [9:0]  A_idx_out,
    output logic [23:0] pk_A_out,
    input  logic        A_ready_in,
    output logic        s_valid_out,
    output logic [9:0]  s_idx_out,
    output logic [3:0]  sk_s_out,
    input  logic        s_ready_in,
    input  logic        B_valid_in,
    output logic [19:0] b_count_out
`ifdef MM_SCHED_PERF_EN
    ,
    output logic [19:0] stall_cycles_out
`endif
);

    localparam int               LAT_W    = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [9:0]       J_LAST   = 10'(DEPTH / 4 - 1);
    localparam logic [9:0]       A_LAST   = 10'(A_WORDS - 1);
    localparam logic [19:0]      B_TARGET = 20'(A_WORDS * (DEPTH / 4));

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_OFFER_A, S_FETCH_S, S_OFFER_S, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [9:0]         a_q, a_d;
    logic [9:0]         j_q, j_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               a_valid_q, a_valid_d;
    logic [9:0]         a_idx_q, a_idx_d;
    logic [23:0]        pk_a_q, pk_a_d;
    logic               s_valid_q, s_valid_d;
    logic [9:0]         s_idx_q, s_idx_d;
    logic [3:0]         sk_s_q, sk_s_d;
    logic [19:0]        b_count_q, b_count_d;
`ifdef MM_SCHED_PERF_EN
    logic [19:0]        stall_q, stall_d;
`endif

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        a_d       = a_q;
        j_d       = j_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        a_valid_d = a_valid_q;
        a_idx_d   = a_idx_q;
        pk_a_d    = pk_a_q;
        s_valid_d = s_valid_q;
        s_idx_d   = s_idx_q;
        sk_s_d    = sk_s_q;
        b_count_d = b_count_q;

        // Results are counted in every busy state, including while still issuing.
        if (busy_q && B_valid_in && !(&b_count_q)) begin
            b_count_d = b_count_q + 20'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d   = S_FETCH_A;
                    a_d       = '0;
                    lat_d     = '0;
                    busy_d    = 1'b1;
                    b_count_d = '0;
                end
            end
            S_FETCH_A: begin
                if (lat_q == LAT_LAST) begin
                    pk_a_d    = a_rd_data_in;
                    a_idx_d   = {a_q[7:0], 2'b00};
                    a_valid_d = 1'b1;
                    state_d   = S_OFFER_A;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_OFFER_A: begin
                if (A_ready_in) begin
                    a_valid_d = 1'b0;
                    j_d       = '0;
                    lat_d     = '0;
                    state_d   = S_FETCH_S;
                end
            end
            S_FETCH_S: begin
                if (lat_q == LAT_LAST) begin
                    sk_s_d    = s_rd_data_in;
                    s_idx_d   = {j_q[7:0], 2'b00};
                    s_valid_d = 1'b1;
                    state_d   = S_OFFER_S;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_OFFER_S: begin
                if (s_ready_in) begin
                    s_valid_d = 1'b0;
                    lat_d     = '0;
                    if (j_q < J_LAST) begin
                        j_d     = j_q + 10'd1;
                        state_d = S_FETCH_S;
                    end else if (a_q < A_LAST) begin
                        a_d     = a_q + 10'd1;
                        state_d = S_FETCH_A;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // >= rather than == so stray extra strobes cannot strand the job here.
                if (b_count_q >= B_TARGET) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MM_SCHED_PERF_EN
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start_in) begin
            stall_d = '0;
        end else if (busy_q && ((a_valid_q && !A_ready_in) || (s_valid_q && !s_ready_in))
                     && !(&stall_q)) begin
            stall_d = stall_q + 20'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles_out = stall_q;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            a_q       <= '0;
            j_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_valid_q <= 1'b0;
            a_idx_q   <= '0;
            pk_a_q    <= '0;
            s_valid_q <= 1'b0;
            s_idx_q   <= '0;
            sk_s_q    <= '0;
            b_count_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            a_q       <= a_d;
            j_q       <= j_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            a_valid_q <= a_valid_d;
            a_idx_q   <= a_idx_d;
            pk_a_q    <= pk_a_d;
            s_valid_q <= s_valid_d;
            s_idx_q   <= s_idx_d;
            sk_s_q    <= sk_s_d;
            b_count_q <= b_count_d;
        end
    end

    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign a_addr_out  = a_q;
    assign s_addr_out  = j_q;
    assign A_valid_out = a_valid_q;
    assign A_idx_out   = a_idx_q;
    assign pk_A_out    = pk_a_q;
    assign s_valid_out = s_valid_q;
    assign s_idx_out   = s_idx_q;
    assign sk_s_out    = sk_s_q;
    assign b_count_out = b_count_q;

endmodule
